// File: rtl/spiker_writer.sv
// Output-layer spike accumulator: counts output-neuron spikes over N_STEPS timesteps,
// then scans the counters one neuron per cycle to report the most active neuron.
module spiker_writer #(
    parameter int N_OUT   = 10,
    parameter int N_STEPS = 25,
    parameter int CNT_W   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       spikes_valid_i,
    input  logic [N_OUT-1:0]           spikes_i,
    input  logic                       clear_i,
    output logic                       sample_o,
    output logic [N_OUT*CNT_W-1:0]     counts_o,
    output logic [$clog2(N_OUT)-1:0]   winner_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       irq_o,
    output logic                       overrun_o
);

    localparam int IDX_W  = $clog2(N_OUT);
    localparam int STEP_W = $clog2(N_STEPS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_ARGMAX = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [N_OUT];
    logic [CNT_W-1:0]  cnt_d [N_OUT];
    logic [STEP_W-1:0] step_q, step_d;
    logic [IDX_W-1:0]  scan_q, scan_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [CNT_W-1:0]  best_val_q, best_val_d;
    logic [IDX_W-1:0]  winner_q, winner_d;
    logic              sample_q, sample_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic              overrun_q, overrun_d;
    logic              launch_s;
    logic              in_busy_s;
    logic              better_s;
    logic [CNT_W-1:0]  scan_val_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    assign in_busy_s = (state_q == S_ACCUM) || (state_q == S_ARGMAX);
    assign launch_s  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state logic: a launch from IDLE/DONE overrides everything else.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        scan_d     = scan_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        winner_d   = winner_q;
        done_d     = done_q;
        sample_d   = 1'b0;
        irq_d      = 1'b0;
        scan_val_s = cnt_q[scan_q];
        better_s   = (scan_q == IDX_W'(0)) || (scan_val_s > best_val_q);

        if (clear_i) begin
            overrun_d = 1'b0;
        end else if (start_i && in_busy_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        if (launch_s) begin
            state_d  = S_ACCUM;
            step_d   = STEP_W'(0);
            scan_d   = IDX_W'(0);
            winner_d = IDX_W'(0);
            done_d   = 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_d[i] = CNT_W'(0);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_ACCUM: begin
                    if (spikes_valid_i) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            cnt_d[i] = sat_inc(cnt_q[i], spikes_i[i]);
                        end
                        if (step_q == STEP_W'(N_STEPS - 1)) begin
                            state_d = S_ARGMAX;
                            scan_d  = IDX_W'(0);
                        end else begin
                            step_d   = step_q + STEP_W'(1);
                            sample_d = 1'b1;
                        end
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
                S_ARGMAX: begin
                    // Strictly-greater update keeps ties on the lowest index.
                    if (better_s) begin
                        best_idx_d = scan_q;
                        best_val_d = scan_val_s;
                    end else begin
                        best_idx_d = best_idx_q;
                    end
                    if (scan_q == IDX_W'(N_OUT - 1)) begin
                        state_d  = S_DONE;
                        winner_d = better_s ? scan_q : best_idx_q;
                        done_d   = 1'b1;
                        irq_d    = 1'b1;
                        scan_d   = IDX_W'(0);
                    end else begin
                        scan_d = scan_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (clear_i) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == S_ACCUM) || (state_d == S_ARGMAX);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            step_q     <= STEP_W'(0);
            scan_q     <= IDX_W'(0);
            best_idx_q <= IDX_W'(0);
            best_val_q <= CNT_W'(0);
            winner_q   <= IDX_W'(0);
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= CNT_W'(0);
            end
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            scan_q     <= scan_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            winner_q   <= winner_d;
            sample_q   <= sample_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack the counter registers onto the flat output bus.
    always_comb begin
        counts_o = '0;
        for (int i = 0; i < N_OUT; i++) begin
            counts_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign sample_o  = sample_q;
    assign winner_o  = winner_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign irq_o     = irq_q;
    assign overrun_o = overrun_q;

endmodule
